// File: rtl/dbg_event_packer.sv
// Serialises single-cycle debug events into a header qword plus N_WORDS payload qwords (MS qword first).
// Latency: header written the cycle after the strobe, payload on the following cycles; N_WORDS+2 cycles per event.
// Backpressure: fifo_full stalls the current qword in place; strobes arriving while busy are dropped and counted.
module dbg_event_packer #(
   parameter int          N_WORDS = 4,
   parameter logic [7:0]  MARKER  = 8'hA5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   evt_strobe,
   input  logic [7:0]             evt_tag,
   input  logic [64*N_WORDS-1:0]  evt_data,
   input  logic                   fifo_full,
   output logic                   fifo_we,
   output logic [63:0]            fifo_data,
   output logic                   busy,
   output logic [7:0]             drop_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      HEADER,
      PAYLOAD
   } state_t;

   localparam logic [3:0] LAST_IDX = 4'(N_WORDS - 1);

   state_t                  state;
   state_t                  state_nxt;
   logic [23:0]             timestamp;
   logic [15:0]             seq;
   logic [3:0]              idx;
   logic [64*N_WORDS-1:0]   payload_q;
   logic [7:0]              tag_q;
   logic [23:0]             ts_snap;
   logic [7:0]              drop_snap;
   logic                    accept;
   logic                    hdr_wr;
   logic                    pay_wr;

   // An event is only captured from IDLE; anything else counts as a drop.
   assign accept = (state == IDLE) && evt_strobe;
   assign busy   = (state != IDLE);

   // Next-state and FIFO write port; the write is gated by fifo_full so a stall never emits.
   always_comb begin
      state_nxt = state;
      fifo_we   = 1'b0;
      fifo_data = 64'h0;
      hdr_wr    = 1'b0;
      pay_wr    = 1'b0;
      case (state)
         IDLE: begin
            if (evt_strobe) begin
               state_nxt = HEADER;
            end
         end
         HEADER: begin
            if (!fifo_full) begin
               fifo_we   = 1'b1;
               fifo_data = {MARKER, tag_q, seq, drop_snap, ts_snap};
               hdr_wr    = 1'b1;
               state_nxt = PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (!fifo_full) begin
               fifo_we   = 1'b1;
               fifo_data = payload_q[(N_WORDS - 1 - int'(idx)) * 64 +: 64];
               pay_wr    = 1'b1;
               if (idx == LAST_IDX) begin
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State register and free-running timestamp.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         timestamp <= 24'h0;
      end else begin
         state     <= state_nxt;
         timestamp <= timestamp + 24'h1;
      end
   end

   // Event capture: payload, tag and the timestamp/drop count seen in the strobe cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         payload_q <= '0;
         tag_q     <= 8'h0;
         ts_snap   <= 24'h0;
         drop_snap <= 8'h0;
      end else if (accept) begin
         payload_q <= evt_data;
         tag_q     <= evt_tag;
         ts_snap   <= timestamp;
         drop_snap <= drop_cnt;
      end
   end

   // Sequence number advances per header written; idx walks the payload qwords.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seq <= 16'h0;
         idx <= 4'h0;
      end else if (hdr_wr) begin
         seq <= seq + 16'h1;
         idx <= 4'h0;
      end else if (pay_wr && (idx != LAST_IDX)) begin
         idx <= idx + 4'h1;
      end
   end

   // Drop counter: cleared when its value is handed to a header, saturates at 255 otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_cnt <= 8'h0;
      end else if (accept) begin
         drop_cnt <= 8'h0;
      end else if (evt_strobe && (drop_cnt != 8'hFF)) begin
         drop_cnt <= drop_cnt + 8'h1;
      end
   end

endmodule

// File: tb/tb_dbg_event_packer.sv
// Randomised and directed bench for dbg_event_packer against a transaction-level queue model.
// One N_WORDS=4 instance is model-checked every cycle; an N_WORDS=1 instance gets directed checks.
// Outputs are sampled 1 time unit after the falling edge, with inputs already settled.
module tb_dbg_event_packer;

   localparam int NW = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            evt_strobe = 1'b0;
   logic [7:0]      evt_tag = 8'h0;
   logic [64*NW-1:0] evt_data = '0;
   logic            fifo_full = 1'b0;
   logic            fifo_we;
   logic [63:0]     fifo_data;
   logic            busy;
   logic [7:0]      drop_cnt;

   logic            s1_strobe = 1'b0;
   logic [7:0]      s1_tag = 8'h0;
   logic [63:0]     s1_data = 64'h0;
   logic            s1_full = 1'b0;
   logic            s1_we;
   logic [63:0]     s1_fdata;
   logic            s1_busy;
   logic [7:0]      s1_drop;

   int              n_checks = 0;
   int              n_fail = 0;

   // Reference model: pending qwords in write order, plus header fields.
   logic [63:0]     exp_q[$];
   logic [15:0]     m_seq = 16'h0;
   logic [7:0]      m_drops = 8'h0;
   logic [23:0]     m_ts = 24'h0;

   always #5 clk = ~clk;

   dbg_event_packer #(.N_WORDS(NW), .MARKER(8'hA5)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .evt_strobe (evt_strobe),
      .evt_tag    (evt_tag),
      .evt_data   (evt_data),
      .fifo_full  (fifo_full),
      .fifo_we    (fifo_we),
      .fifo_data  (fifo_data),
      .busy       (busy),
      .drop_cnt   (drop_cnt)
   );

   dbg_event_packer #(.N_WORDS(1), .MARKER(8'hA5)) u_dut1 (
      .clk        (clk),
      .rst        (rst),
      .evt_strobe (s1_strobe),
      .evt_tag    (s1_tag),
      .evt_data   (s1_data),
      .fifo_full  (s1_full),
      .fifo_we    (s1_we),
      .fifo_data  (s1_fdata),
      .busy       (s1_busy),
      .drop_cnt   (s1_drop)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [64*NW-1:0] rand_data();
      logic [64*NW-1:0] d;
      for (int i = 0; i < 2 * NW; i++) begin
         d[32*i +: 32] = $urandom;
      end
      return d;
   endfunction

   // One clock: drive inputs, check outputs against the model, then advance the model past the rising edge.
   task automatic cycle(input logic stb, input logic full, input logic [7:0] tag, input logic [64*NW-1:0] data);
      logic in_flight;
      @(negedge clk);
      evt_strobe = stb;
      fifo_full  = full;
      evt_tag    = tag;
      evt_data   = data;
      #1;
      in_flight = (exp_q.size() != 0);
      check_eq("busy", 64'(busy), 64'(in_flight));
      check_eq("drop_cnt", 64'(drop_cnt), 64'(m_drops));
      if (in_flight && !full) begin
         check_eq("fifo_we", 64'(fifo_we), 64'h1);
         check_eq("fifo_data", fifo_data, exp_q.pop_front());
      end else begin
         check_eq("fifo_we_idle", 64'(fifo_we), 64'h0);
         check_eq("fifo_data_idle", fifo_data, 64'h0);
      end
      if (stb) begin
         if (!in_flight) begin
            exp_q.push_back({8'hA5, tag, m_seq, m_drops, m_ts});
            m_seq = m_seq + 16'h1;
            for (int i = NW - 1; i >= 0; i--) begin
               exp_q.push_back(data[64*i +: 64]);
            end
            m_drops = 8'h0;
         end else if (m_drops != 8'hFF) begin
            m_drops = m_drops + 8'h1;
         end
      end
      m_ts = m_ts + 24'h1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         cycle(1'b0, 1'b0, 8'($urandom), rand_data());
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      evt_strobe = 1'b0;
      fifo_full  = 1'b0;
      s1_strobe  = 1'b0;
      rst        = 1'b0;
      #1;
      check_eq("rst_we", 64'(fifo_we), 64'h0);
      check_eq("rst_data", fifo_data, 64'h0);
      check_eq("rst_busy", 64'(busy), 64'h0);
      check_eq("rst_drop", 64'(drop_cnt), 64'h0);
      check_eq("rst1_we", 64'(s1_we), 64'h0);
      check_eq("rst1_busy", 64'(s1_busy), 64'h0);
      exp_q.delete();
      m_seq   = 16'h0;
      m_drops = 8'h0;
      m_ts    = 24'h0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      logic [23:0] t1;
      do_reset();

      // Single event at timestamp 0x10 with the reference tag/data.
      idle(16);
      cycle(1'b1, 1'b0, 8'h3C, {{4{16'h1111}}, {4{16'h2222}}, {4{16'h3333}}, {4{16'h4444}}});
      idle(1);
      check_eq("hdr_ref", fifo_data, 64'hA53C_0000_0000_0010);
      idle(5);
      check_eq("busy_after6", 64'(busy), 64'h0);

      // Back-to-back events at minimum spacing.
      for (int e = 0; e < 3; e++) begin
         cycle(1'b1, 1'b0, 8'($urandom), rand_data());
         idle(NW + 1);
      end
      idle(2);

      // Sequence wrap.
      force u_dut.seq = 16'hFFFF;
      #1;
      release u_dut.seq;
      m_seq = 16'hFFFF;
      cycle(1'b1, 1'b0, 8'h11, rand_data());
      idle(NW + 1);
      cycle(1'b1, 1'b0, 8'h22, rand_data());
      idle(NW + 3);

      // Three drops, then reported in the next header.
      cycle(1'b1, 1'b0, 8'h33, rand_data());
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'($urandom), rand_data());
      idle(4);
      check_eq("drop3", 64'(drop_cnt), 64'h3);
      cycle(1'b1, 1'b0, 8'h44, rand_data());
      idle(NW + 3);

      // Saturation: hold the header stalled while 300 strobes arrive.
      cycle(1'b1, 1'b0, 8'h55, rand_data());
      for (int i = 0; i < 300; i++) cycle(1'b1, 1'b1, 8'($urandom), rand_data());
      idle(1);
      check_eq("drop_sat", 64'(drop_cnt), 64'hFF);
      idle(NW + 3);

      // Backpressure: 7 stalls at the header, 3 after the first payload qword.
      cycle(1'b1, 1'b0, 8'h66, rand_data());
      for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 8'h0, rand_data());
      idle(2);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h0, rand_data());
      idle(NW + 2);
      check_eq("bp_drained", 64'(exp_q.size()), 64'h0);

      // Reset in the middle of the payload, after two qwords.
      cycle(1'b1, 1'b0, 8'h77, rand_data());
      idle(3);
      do_reset();
      idle(5);
      cycle(1'b1, 1'b0, 8'h78, rand_data());
      idle(NW + 3);

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), 8'($urandom), rand_data());
      end
      idle(40);
      check_eq("rand_drained", 64'(exp_q.size()), 64'h0);

      // N_WORDS=1 instance: two writes per event, strobe on the payload write is dropped.
      s1_tag  = 8'h9D;
      s1_data = 64'hDEAD_BEEF_0123_4567;
      idle(1);
      s1_strobe = 1'b1;
      t1 = m_ts - 24'h1;
      idle(1);
      s1_strobe = 1'b0;
      #1;
      check_eq("n1_hdr_we", 64'(s1_we), 64'h1);
      check_eq("n1_hdr", s1_fdata, {8'hA5, 8'h9D, 16'h0000, 8'h00, t1});
      idle(1);
      s1_strobe = 1'b1;
      #1;
      check_eq("n1_pay_we", 64'(s1_we), 64'h1);
      check_eq("n1_pay", s1_fdata, 64'hDEAD_BEEF_0123_4567);
      idle(1);
      s1_strobe = 1'b0;
      #1;
      check_eq("n1_idle_we", 64'(s1_we), 64'h0);
      check_eq("n1_busy", 64'(s1_busy), 64'h0);
      check_eq("n1_drop", 64'(s1_drop), 64'h1);
      s1_strobe = 1'b1;
      idle(1);
      s1_strobe = 1'b0;
      #1;
      check_eq("n1_hdr2", s1_fdata[63:24], {8'hA5, 8'h9D, 16'h0001, 8'h01});
      check_eq("n1_drop_clr", 64'(s1_drop), 64'h0);
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
